// File: rtl/lbp_pkg.sv
//============================================================================
// Module      : lbp_pkg
// Description : Shared constants and types for the LBP histogram block.
//               Holds the bin count, image geometry, default counter width,
//               expected interior pixel count and the readout FSM encoding.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

package lbp_pkg;

    localparam int LBP_BINS    = 256;
    localparam int BIN_W       = 8;
    localparam int IMG_W       = 128;
    localparam int ADDR_W      = $clog2(IMG_W * IMG_W);
    localparam int CNT_W_DEF   = 14;
    // Interior of an IMG_W x IMG_W frame: (IMG_W-2)^2 = 126*126
    localparam int EXP_PIX_DEF = (IMG_W - 2) * (IMG_W - 2);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lbp_hist_if.sv
//============================================================================
// Module      : lbp_hist_if
// Description : Bundle between the LBP stage / histogram sink and lbp_hist.
//               master : drives LBP results, finish and hist_ready.
//               slave  : the histogram block; drives the readout stream.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

interface lbp_hist_if
    import lbp_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic               lbp_valid;
    logic [ADDR_W-1:0]  lbp_addr;
    logic [BIN_W-1:0]   lbp_data;
    logic               finish;
    logic               hist_valid;
    logic [BIN_W-1:0]   hist_bin;
    logic [CNT_W-1:0]   hist_count;
    logic               hist_ready;
    logic               hist_done;
    logic               hist_err;

    modport master (
        output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        input  hist_valid, hist_bin, hist_count, hist_done, hist_err
    );

    modport slave (
        input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        output hist_valid, hist_bin, hist_count, hist_done, hist_err
    );

endinterface

`default_nettype wire

// File: rtl/lbp_hist_ram.sv
//============================================================================
// Module      : lbp_hist_ram
// Description : 256 x CNT_W bin storage, one write port and one async read
//               port. A per-bin "used" bit is cleared by reset so the array
//               itself needs no reset; an unused bin reads as zero.
// Ports       : clk, rst      clock / async active-high reset
//               i_we/i_waddr/i_wdata   write port (sets the used bit)
//               i_raddr/o_rdata        combinational read port
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module lbp_hist_ram
    import lbp_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_we,
    input  wire logic [BIN_W-1:0]   i_waddr,
    input  wire logic [CNT_W-1:0]   i_wdata,
    input  wire logic [BIN_W-1:0]   i_raddr,
    output logic      [CNT_W-1:0]   o_rdata
);

    logic [CNT_W-1:0]    r_mem [LBP_BINS];
    logic [LBP_BINS-1:0] r_used;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_used <= '0;
        end else if (i_we) begin
            r_used[i_waddr] <= 1'b1;
        end
    end

    assign o_rdata = r_used[i_raddr] ? r_mem[i_raddr] : '0;

endmodule

`default_nettype wire

// File: rtl/lbp_hist.sv
//============================================================================
// Module      : lbp_hist
// Description : Builds a 256-bin histogram of LBP codes for one frame, then
//               streams all bins out over valid/ready and reports whether
//               the counted pixel total matched EXP_PIX.
// Ports       : clk    system clock
//               reset  asynchronous active-high reset
//               bus    lbp_hist_if.slave (LBP input, finish, readout stream,
//                      hist_done / hist_err status)
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module lbp_hist
    import lbp_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int EXP_PIX = EXP_PIX_DEF
) (
    input  wire logic   clk,
    input  wire logic   reset,
    lbp_hist_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t             r_state, w_state_nxt;
    logic               r_drain_cnt;
    logic               r_prev_valid;
    logic [ADDR_W-1:0]  r_last_addr;
    logic               w_event, w_count_ev;

    logic               r_s1_valid;
    logic [BIN_W-1:0]   r_s1_bin;
    logic               r_s2_valid;
    logic [BIN_W-1:0]   r_s2_bin;
    logic [CNT_W-1:0]   r_s2_cnt;
    logic [CNT_W-1:0]   w_rd, w_base, w_inc;
    logic [BIN_W-1:0]   w_raddr;

    logic               r_hist_valid;
    logic [BIN_W-1:0]   r_hist_bin;
    logic [CNT_W-1:0]   r_hist_count;
    logic [CNT_W-1:0]   r_total;

    // A held-high valid with an unchanged address is one pixel, not many.
    assign w_event    = bus.lbp_valid && (!r_prev_valid || (bus.lbp_addr != r_last_addr));
    assign w_count_ev = w_event && (r_state == ST_ACCUM);

    // The single read port serves the accumulate pipe until readout starts.
    assign w_raddr = (r_state == ST_READ) ? r_hist_bin : r_s1_bin;

    // S1 reads the RAM while S2 still holds the pending write for the
    // previous event; if both target the same bin, take S2's value.
    assign w_base = (r_s2_valid && (r_s2_bin == r_s1_bin)) ? r_s2_cnt : w_rd;
    assign w_inc  = (w_base == c_cnt_max) ? w_base : w_base + CNT_W'(1);

    lbp_hist_ram #(.CNT_W(CNT_W)) u_ram (
        .clk     (clk),
        .rst     (reset),
        .i_we    (r_s2_valid),
        .i_waddr (r_s2_bin),
        .i_wdata (r_s2_cnt),
        .i_raddr (w_raddr),
        .o_rdata (w_rd)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: if (bus.finish) w_state_nxt = ST_DRAIN;
            // Two cycles let the last event pass S1 and S2 into the RAM.
            ST_DRAIN: if (r_drain_cnt) w_state_nxt = ST_READ;
            ST_READ:  if (r_hist_valid && bus.hist_ready && (r_hist_bin == 8'hFF))
                          w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_ACCUM;
        endcase
    end

    // ---------------- event qualification and accumulate pipe ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_valid <= 1'b0;
            r_last_addr  <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_bin     <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_bin     <= '0;
            r_s2_cnt     <= '0;
            r_total      <= '0;
            r_drain_cnt  <= 1'b0;
        end else begin
            r_prev_valid <= bus.lbp_valid;
            if (w_event) begin
                r_last_addr <= bus.lbp_addr;
            end
            r_s1_valid <= w_count_ev;
            if (w_count_ev) begin
                r_s1_bin <= bus.lbp_data;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_bin <= r_s1_bin;
                r_s2_cnt <= w_inc;
            end
            if (w_count_ev && (r_total != c_cnt_max)) begin
                r_total <= r_total + CNT_W'(1);
            end
            r_drain_cnt <= (r_state == ST_DRAIN);
        end
    end

    // ---------------- readout ----------------
    // Each bin gets one fetch cycle (valid low) before it is presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist_valid <= 1'b0;
            r_hist_bin   <= '0;
            r_hist_count <= '0;
        end else if (r_state == ST_READ) begin
            if (!r_hist_valid) begin
                r_hist_valid <= 1'b1;
                r_hist_count <= w_rd;
            end else if (bus.hist_ready) begin
                r_hist_valid <= 1'b0;
                if (r_hist_bin != 8'hFF) begin
                    r_hist_bin <= r_hist_bin + 8'd1;
                end
            end
        end
    end

    assign bus.hist_valid = r_hist_valid;
    assign bus.hist_bin   = r_hist_bin;
    assign bus.hist_count = r_hist_count;
    assign bus.hist_done  = (r_state == ST_DONE);
    assign bus.hist_err   = (r_state == ST_DONE) && (r_total != CNT_W'(EXP_PIX));

endmodule

`default_nettype wire

// File: tb/tb_lbp_hist.sv
//============================================================================
// Module      : tb_lbp_hist
// Description : Directed self-checking bench for lbp_hist.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_lbp_hist;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt [256];

    always #5 clk = ~clk;

    lbp_hist_if #(.CNT_W(14)) bus ();

    lbp_hist #(.CNT_W(14), .EXP_PIX(15876)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.lbp_valid = 1'b0; bus.lbp_addr = '0; bus.lbp_data = '0;
        bus.finish = 1'b0;    bus.hist_ready = 1'b0;
        for (int i = 0; i < 256; i++) exp_cnt[i] = 0;
        tick; tick;
        reset = 1'b0;
        tick;
    endtask

    // valid is left high; caller drops it when needed
    task automatic send(input int addr, input int data);
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = 14'(addr);
        bus.lbp_data  = 8'(data);
        exp_cnt[data] = exp_cnt[data] + 1;
        tick;
    endtask

    // Raise finish, collect all bins, check order/counts/latency/status.
    task automatic readout(input int exp_total, input int stall_bin,
                           input int abort_bin, input bit spam);
        int xfers, cyc, sum;
        bit seen;
        xfers = 0; cyc = 0; sum = 0; seen = 0;
        bus.finish = 1'b1;
        bus.hist_ready = 1'b1;
        while (xfers < 256 && cyc < 3000) begin
            tick; cyc++;
            if (spam && bus.lbp_valid) bus.lbp_addr = bus.lbp_addr + 14'd1;
            if (bus.hist_valid) begin
                if (!seen) begin
                    seen = 1;
                    chk("first_latency_le4", 32'(cyc <= 4), 1);
                end
                if (abort_bin == xfers) begin
                    chk("abort_bin", bus.hist_bin, xfers);
                    return;
                end
                chk("bin_order", bus.hist_bin, xfers);
                chk("bin_count", bus.hist_count, exp_cnt[xfers]);
                sum += int'(bus.hist_count);
                if (xfers == stall_bin) begin
                    bus.hist_ready = 1'b0;
                    repeat (7) begin
                        tick; cyc++;
                        chk("stall_valid", bus.hist_valid, 1);
                        chk("stall_bin", bus.hist_bin, xfers);
                        chk("stall_count", bus.hist_count, exp_cnt[xfers]);
                    end
                    bus.hist_ready = 1'b1;
                end
                xfers++;
            end
        end
        chk("xfer_total", xfers, 256);
        tick;
        chk("done", bus.hist_done, 1);
        chk("valid_after_done", bus.hist_valid, 0);
        chk("err", bus.hist_err, 32'(exp_total != 15876));
        chk("bin_sum", sum, exp_total);
        bus.finish = 1'b0; bus.hist_ready = 1'b0; bus.lbp_valid = 1'b0;
    endtask

    initial begin
        logic [13:0] a;

        // Reset state
        do_reset;
        chk("rst_valid", bus.hist_valid, 0);
        chk("rst_bin",   bus.hist_bin,   0);
        chk("rst_count", bus.hist_count, 0);
        chk("rst_done",  bus.hist_done,  0);
        chk("rst_err",   bus.hist_err,   0);

        // Single pixel: code A5 at addr 129
        do_reset;
        send(129, 8'hA5);
        bus.lbp_valid = 1'b0;
        tick;
        readout(1, -1, -1, 0);

        // Held valid: same address for 5 cycles counts once; finish while high
        do_reset;
        bus.lbp_valid = 1'b1; bus.lbp_addr = 14'd200; bus.lbp_data = 8'h3C;
        exp_cnt[8'h3C] = 1;
        repeat (5) tick;
        readout(1, -1, -1, 0);

        // Back-to-back same bin, 10 events
        do_reset;
        for (int i = 0; i < 10; i++) send(129 + i, 0);
        readout(10, -1, -1, 0);

        // Alternating 0/1, last event coincides with finish
        do_reset;
        for (int i = 0; i < 9; i++) send(129 + i, i % 2);
        bus.lbp_valid = 1'b1; bus.lbp_addr = 14'd138; bus.lbp_data = 8'd1;
        exp_cnt[1] = exp_cnt[1] + 1;
        readout(10, -1, -1, 0);

        // Backpressure at bin 42
        do_reset;
        send(300, 42); send(301, 42); send(302, 43);
        bus.lbp_valid = 1'b0;
        tick;
        readout(3, 42, -1, 0);

        // Reset mid-READ at bin 100, then a fresh frame
        do_reset;
        send(129, 7); send(130, 7);
        bus.lbp_valid = 1'b0;
        tick;
        readout(2, -1, 100, 0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", bus.hist_valid, 0);
        chk("midrst_bin",   bus.hist_bin,   0);
        chk("midrst_count", bus.hist_count, 0);
        chk("midrst_done",  bus.hist_done,  0);
        do_reset;
        send(500, 7); send(501, 7); send(502, 7);
        bus.lbp_valid = 1'b0;
        tick;
        readout(3, -1, -1, 0);

        // Full frame: all interior pixels, code = addr[7:0]; the last one
        // is presented together with finish and valid is left high, with
        // further addresses arriving during drain/readout (to be dropped).
        do_reset;
        for (int y = 1; y <= 126; y++) begin
            for (int x = 1; x <= 126; x++) begin
                a = 14'(y * 128 + x);
                bus.lbp_valid = 1'b1;
                bus.lbp_addr  = a;
                bus.lbp_data  = a[7:0];
                exp_cnt[a[7:0]] = exp_cnt[a[7:0]] + 1;
                if (!(y == 126 && x == 126)) tick;
            end
        end
        readout(15876, -1, -1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lbp_hist.md
Name: lbp_hist

Overview:
- Downstream consumer of the LBP stage's result interface (lbp_valid, lbp_addr, lbp_data, finish).
- Builds a 256-bin histogram of LBP codes over one 128x128 frame, i.e. the 126x126 interior pixels.
- Once finish is seen, streams all 256 bins out in order over a valid/ready handshake.
- Also reports a pixel-count integrity flag.

Parameters:
- CNT_W, 14, width of each bin counter and of the total-pixel counter.
- EXP_PIX, 15876, expected number of counted pixels per frame (126*126).

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- lbp_valid  input  1  LBP result valid; may stay high across cycles
- lbp_addr  input  14  pixel address of the current LBP result
- lbp_data  input  8  LBP code = histogram bin index
- finish  input  1  frame complete from LBP stage; level, stays high
- hist_valid  output  1  readout bin valid
- hist_bin  output  8  bin index being presented
- hist_count  output  CNT_W  count for hist_bin
- hist_ready  input  1  sink accepts the current bin
- hist_done  output  1  all 256 bins delivered; sticky until reset
- hist_err  output  1  total counted pixels != EXP_PIX; valid when hist_done=1

Behaviour:
- Reset (async, active-high): state=ACCUM; bins logically cleared via 256-bit bin_used vector (a bin with used=0 reads as 0); total=0; hist_valid=0, hist_bin=0, hist_count=0, hist_done=0, hist_err=0; last_addr=0, prev_valid=0.
- Reset mid-operation, in any state, abandons the frame; no partial output.
- Event qualification: the upstream stage holds lbp_valid high for one cycle per pixel, but may leave it high after the last pixel.
  - Event = lbp_valid && (!prev_valid || lbp_addr != last_addr).
  - On an event, capture last_addr <= lbp_addr.
  - prev_valid <= lbp_valid every cycle.
  - A held-high lbp_valid with an unchanged address counts exactly once.
- Accumulate pipeline, 2 stages:
  - S1 registers bin index = lbp_data.
  - S2 does read-modify-write, count+1 saturating at 2^CNT_W-1, and sets bin_used.
  - Back-to-back events on the same bin must forward the S2 result into S1; no lost increments.
  - total increments per event, saturating.
- FSM states: ACCUM, DRAIN, READ, DONE.
  - ACCUM: count events. When finish=1, go to DRAIN. An event in the same cycle as finish is still counted.
  - DRAIN: fixed 2 cycles to empty the pipeline; new events are ignored. Then go to READ with hist_bin=0.
  - READ: hist_valid=1. hist_bin and hist_count are stable while hist_ready=0.
    - Transfer = hist_valid && hist_ready.
    - On a transfer with hist_bin<255: hist_bin+1; next count presented the following cycle. hist_valid may drop for one fetch cycle between bins.
    - On a transfer with hist_bin=255: hist_valid=0, go to DONE.
  - DONE: hist_done=1 and hist_err=(total != EXP_PIX); hold. Ignore all inputs until reset.
- Events arriving in DRAIN, READ or DONE are dropped and not counted.
- Latency: finish to first hist_valid is at most 4 cycles.

Decomposition:
- Shared package lbp_pkg: LBP_BINS=256, IMG_W=128, CNT_W default, EXP_PIX.
- One sub-module, lbp_hist_ram: 256 x CNT_W storage with 1 read and 1 write port, plus the bin_used vector with async clear.

Test Plan:
- Single pixel: reset, one event lbp_data=8'hA5 at addr 129, then finish=1 → readout gives bin 165 count 1, all other bins 0; hist_done=1, hist_err=1.
- Held valid: lbp_valid high 5 cycles with addr 200 unchanged, then finish → bin count is 1, not 5.
- Back-to-back: events every cycle, addrs 129..138, all lbp_data=8'h00 → bin 0 count=10; also alternate codes 0/1 → counts 5/5.
- Full frame: 15876 events with lbp_data = addr[7:0], final lbp_valid left high with finish → total 15876, hist_err=0, sum of all bins = 15876.
- Backpressure: hold hist_ready=0 for 7 cycles mid-readout at bin 42 → bin and count stable; no bin skipped or repeated; 256 transfers total.
- Reset mid-READ at bin 100 → outputs return to reset values; a new frame of 3 events to bin 7 reads back count 3, not accumulated with the prior frame.
